pipelined_subtractor: RTL and testbench

PIPELINED_SUBTRACTOR -- requirements
Module: pipelined_subtractor

---
 rtl/pipelined_subtractor_pkg.sv | 39 +++
 rtl/pipelined_subtractor_bk_prefix_levels.sv | 53 +++++
 rtl/pipelined_subtractor.sv | 139 +++++++++++++
 tb/tb_pipelined_subtractor.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_subtractor_pkg.sv
// Shared width default and Brent-Kung level bookkeeping for the pipelined subtractor.
// Levels 1..L are the up-sweep, levels L+1..2L-1 the down-sweep (L = clog2(N)).
package pipelined_subtractor_pkg;

    localparam int DEFAULT_N = 8;

    function automatic int total_levels(input int n);
        return 2 * $clog2(n) - 1;
    endfunction

    // Stage 1 takes the first half of the up-sweep; stage 2 finishes the tree.
    function automatic int s1_last_level(input int n);
        return ($clog2(n) + 1) / 2;
    endfunction

    function automatic int level_log_stride(input int n, input int lv);
        int l;
        if (lv <= $clog2(n)) begin
            l = lv;
        end else begin
            l = 2 * $clog2(n) - lv;
        end
        return l;
    endfunction

    function automatic int node_span(input int n, input int lv);
        return 1 << (level_log_stride(n, lv) - 1);
    endfunction

    function automatic bit node_active(input int n, input int lv, input int i);
        int blk;
        blk = 1 << level_log_stride(n, lv);
        if (lv <= $clog2(n)) begin
            return ((i + 1) % blk) == 0;
        end
        return (((i + 1) % blk) == (blk / 2)) && (i >= blk);
    endfunction

endpackage

// File: rtl/pipelined_subtractor_bk_prefix_levels.sv
// Combinational Brent-Kung prefix levels FIRST..LAST over G/P vectors; empty range passes through.
// Zero latency, no flow control.
module bk_prefix_levels
    import pipelined_subtractor_pkg::*;
#(
    parameter int N     = DEFAULT_N,
    parameter int FIRST = 1,
    parameter int LAST  = 1
) (
    input  logic [N-1:0] g_i,
    input  logic [N-1:0] p_i,
    output logic [N-1:0] g_o,
    output logic [N-1:0] p_o
);

    localparam int NLV = (LAST >= FIRST) ? (LAST - FIRST + 1) : 0;

    for (genvar k = 0; k < NLV; k++) begin : g_level
        logic [N-1:0] g_in;
        logic [N-1:0] p_in;
        logic [N-1:0] g_out;
        logic [N-1:0] p_out;

        if (k == 0) begin : g_first
            assign g_in = g_i;
            assign p_in = p_i;
        end else begin : g_chain
            assign g_in = g_level[k-1].g_out;
            assign p_in = g_level[k-1].p_out;
        end

        for (genvar i = 0; i < N; i++) begin : g_bit
            localparam int LV = FIRST + k;
            if (node_active(N, LV, i)) begin : g_node
                localparam int J = i - node_span(N, LV);
                assign g_out[i] = g_in[i] | (p_in[i] & g_in[J]);
                assign p_out[i] = p_in[i] & p_in[J];
            end else begin : g_pass
                assign g_out[i] = g_in[i];
                assign p_out[i] = p_in[i];
            end
        end
    end

    if (NLV == 0) begin : g_empty
        assign g_o = g_i;
        assign p_o = p_i;
    end else begin : g_result
        assign g_o = g_level[NLV-1].g_out;
        assign p_o = g_level[NLV-1].p_out;
    end

endmodule

// File: rtl/pipelined_subtractor.sv
// Two-stage Brent-Kung subtractor A - B - Bin with borrow/overflow/zero/neg flags.
// Latency 2 cycles, one result per cycle; stalls hold both stages, in_ready follows out_ready combinationally.
module pipelined_subtractor
    import pipelined_subtractor_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         CLOCK_50,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Diff,
    output logic         Bout,
    output logic         overflow,
    output logic         zero,
    output logic         neg
);

    localparam int S1_LAST = s1_last_level(N);
    localparam int TOTAL   = total_levels(N);

    logic [N-1:0] g0, p0, g1, p1, g2, p2;
    logic [N:0]   carry;
    logic [N-1:0] sum;
    logic         unused_p2;

    logic         s1_vld_q, s1_vld_d;
    logic [N-1:0] s1_g_q, s1_g_d;
    logic [N-1:0] s1_p_q, s1_p_d;
    logic [N-1:0] s1_p0_q, s1_p0_d;
    logic         s1_cin_q, s1_cin_d;

    logic         s2_vld_q, s2_vld_d;
    logic [N-1:0] diff_q, diff_d;
    logic         bout_q, bout_d;
    logic         ovf_q, ovf_d;
    logic         zero_q, zero_d;
    logic         neg_q, neg_d;

    logic         s1_load, s2_load;

    // Subtraction as A + ~B + ~Bin; the carry-in is folded into bit 0's generate.
    always_comb begin
        p0    = A ^ ~B;
        g0    = A & ~B;
        g0[0] = g0[0] | (p0[0] & ~Bin);
    end

    bk_prefix_levels #(.N(N), .FIRST(1), .LAST(S1_LAST)) u_s1_levels (
        .g_i (g0),
        .p_i (p0),
        .g_o (g1),
        .p_o (p1)
    );

    bk_prefix_levels #(.N(N), .FIRST(S1_LAST + 1), .LAST(TOTAL)) u_s2_levels (
        .g_i (s1_g_q),
        .p_i (s1_p_q),
        .g_o (g2),
        .p_o (p2)
    );

    assign unused_p2 = ^p2;
    assign carry     = {g2, s1_cin_q};
    assign sum       = s1_p0_q ^ carry[N-1:0];

    always_comb begin
        s2_load  = !s2_vld_q || out_ready;
        s1_load  = !s1_vld_q || s2_load;

        s1_vld_d = s1_load ? in_valid : s1_vld_q;
        s1_g_d   = s1_g_q;
        s1_p_d   = s1_p_q;
        s1_p0_d  = s1_p0_q;
        s1_cin_d = s1_cin_q;
        if (s1_load && in_valid) begin
            s1_g_d   = g1;
            s1_p_d   = p1;
            s1_p0_d  = p0;
            s1_cin_d = ~Bin;
        end

        s2_vld_d = s2_load ? s1_vld_q : s2_vld_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        if (s2_load && s1_vld_q) begin
            diff_d = sum;
            bout_d = ~carry[N];
            ovf_d  = carry[N] ^ carry[N-1];
            zero_d = (sum == '0);
            neg_d  = sum[N-1];
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_g_q   <= '0;
            s1_p_q   <= '0;
            s1_p0_q  <= '0;
            s1_cin_q <= 1'b0;
            s2_vld_q <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_g_q   <= s1_g_d;
            s1_p_q   <= s1_p_d;
            s1_p0_q  <= s1_p0_d;
            s1_cin_q <= s1_cin_d;
            s2_vld_q <= s2_vld_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
        end
    end

    assign in_ready  = s1_load;
    assign out_valid = s2_vld_q;
    assign Diff      = diff_q;
    assign Bout      = bout_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;
    assign neg       = neg_q;

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Directed and randomised checks of pipelined_subtractor at N=8 and N=13.
module tb_pipelined_subtractor;

    localparam int NRAND  = 10000;
    localparam int BUDGET = 60000;

    logic        clk;
    logic        rst_n;

    logic        in_valid8, in_ready8, bin8, out_valid8, out_ready8;
    logic [7:0]  a8, b8, diff8;
    logic        bout8, ovf8, zero8, neg8;

    logic        in_valid13, in_ready13, bin13, out_valid13, out_ready13;
    logic [12:0] a13, b13, diff13;
    logic        bout13, ovf13, zero13, neg13;

    int checks = 0;
    int errors = 0;

    pipelined_subtractor #(.N(8)) dut8 (
        .CLOCK_50 (clk),        .rst_n     (rst_n),
        .in_valid (in_valid8),  .in_ready  (in_ready8),
        .A        (a8),         .B         (b8),
        .Bin      (bin8),       .out_valid (out_valid8),
        .out_ready(out_ready8), .Diff      (diff8),
        .Bout     (bout8),      .overflow  (ovf8),
        .zero     (zero8),      .neg       (neg8)
    );

    pipelined_subtractor #(.N(13)) dut13 (
        .CLOCK_50 (clk),         .rst_n     (rst_n),
        .in_valid (in_valid13),  .in_ready  (in_ready13),
        .A        (a13),         .B         (b13),
        .Bin      (bin13),       .out_valid (out_valid13),
        .out_ready(out_ready13), .Diff      (diff13),
        .Bout     (bout13),      .overflow  (ovf13),
        .zero     (zero13),      .neg       (neg13)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Packs {diff, bout, ovf} from plain integer arithmetic on A - B - Bin.
    function automatic int ref_pack(input int n, input int a, input int b, input int bin);
        int full, half, r, sa, sb, sr, bout, ovf;
        full = 1 << n;
        half = 1 << (n - 1);
        r    = a - b - bin;
        bout = (r < 0) ? 1 : 0;
        sa   = (a >= half) ? a - full : a;
        sb   = (b >= half) ? b - full : b;
        sr   = sa - sb - bin;
        ovf  = (sr < -half || sr >= half) ? 1 : 0;
        return ((r & (full - 1)) << 2) | (bout << 1) | ovf;
    endfunction

    task automatic run_vec(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bin,
                           input logic [7:0] ediff, input logic ebout, input logic eovf,
                           input logic ezero, input logic eneg);
        @(posedge clk); #1;
        in_valid8 = 1'b1; a8 = a; b8 = b; bin8 = bin; out_ready8 = 1'b1;
        @(negedge clk);
        check({tag, "_acc"}, 32'(in_ready8), 1);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        @(negedge clk);
        check({tag, "_lat1"}, 32'(out_valid8), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_vld"},  32'(out_valid8), 1);
        check({tag, "_diff"}, 32'(diff8), 32'(ediff));
        check({tag, "_bout"}, 32'(bout8), 32'(ebout));
        check({tag, "_ovf"},  32'(ovf8), 32'(eovf));
        check({tag, "_zero"}, 32'(zero8), 32'(ezero));
        check({tag, "_neg"},  32'(neg8), 32'(eneg));
    endtask

    initial begin
        int nxt, exp_out, sent8, recv8, sent13, recv13, cyc;
        bit found, hold8, hold13;
        int q8[$];
        int q13[$];

        rst_n = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        in_valid13 = 1'b0; out_ready13 = 1'b0; a13 = '0; b13 = '0; bin13 = 1'b0;

        // Reset state
        #1;
        check("rst_vld",  32'(out_valid8), 0);
        check("rst_diff", 32'(diff8), 0);
        check("rst_bout", 32'(bout8), 0);
        check("rst_ovf",  32'(ovf8), 0);
        check("rst_zero", 32'(zero8), 0);
        check("rst_neg",  32'(neg8), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready8 = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready8), 1);

        // Directed arithmetic vectors
        run_vec("sub_5_3",   8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
        run_vec("sub_3_5",   8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1);
        run_vec("sub_80_1",  8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0);
        run_vec("sub_0_0_b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
        run_vec("sub_2a_2a", 8'h2A, 8'h2A, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

        // Back-to-back 1..5 with a three-cycle downstream stall
        nxt = 1;
        exp_out = 1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            out_ready8 = !(c >= 3 && c <= 5);
            in_valid8  = (nxt <= 5);
            a8 = 8'(nxt); b8 = 8'h00; bin8 = 1'b0;
            @(negedge clk);
            if (c == 2) check("b2b_rdy_c2", 32'(in_ready8), 1);
            if (c == 3) check("b2b_rdy_full", 32'(in_ready8), 0);
            if (c == 5) begin
                check("b2b_hold_vld",  32'(out_valid8), 1);
                check("b2b_hold_diff", 32'(diff8), 1);
            end
            if (out_valid8 && out_ready8) begin
                check("b2b_order", 32'(diff8), 32'(exp_out));
                exp_out++;
            end
            if (in_valid8 && in_ready8) nxt++;
        end
        check("b2b_count", 32'(exp_out), 6);
        in_valid8 = 1'b0;

        // Reset with two results in flight
        @(posedge clk); #1;
        out_ready8 = 1'b1; in_valid8 = 1'b1; a8 = 8'h11; b8 = 8'h00; bin8 = 1'b0;
        @(posedge clk); #1;
        a8 = 8'h22;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        check("rstmid_pre_vld", 32'(out_valid8), 1);
        rst_n = 1'b0;
        #1;
        check("rstmid_vld",  32'(out_valid8), 0);
        check("rstmid_diff", 32'(diff8), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rstmid_flush", 32'(out_valid8), 0);
            @(posedge clk); #1;
        end
        in_valid8 = 1'b1; a8 = 8'h33; b8 = 8'h03; bin8 = 1'b0;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 6 && !found; c++) begin
            @(negedge clk);
            if (out_valid8) begin
                check("rstmid_first", 32'(diff8), 32'h30);
                found = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        check("rstmid_found", 32'(found), 1);

        // Random operands with random stalls on both widths
        @(posedge clk); #1;
        sent8 = 0; recv8 = 0; sent13 = 0; recv13 = 0; cyc = 0;
        hold8 = 1'b0; hold13 = 1'b0;
        q8.delete();
        q13.delete();
        while (!(recv8 == NRAND && recv13 == NRAND) && cyc < BUDGET) begin
            @(posedge clk); #1;
            cyc++;
            if (!hold8) begin
                in_valid8 = (sent8 < NRAND) && ($urandom_range(0, 3) != 0);
                a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
            end
            out_ready8 = ($urandom_range(0, 3) != 0);
            if (!hold13) begin
                in_valid13 = (sent13 < NRAND) && ($urandom_range(0, 3) != 0);
                a13 = 13'($urandom); b13 = 13'($urandom); bin13 = 1'($urandom);
            end
            out_ready13 = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (out_valid8 && out_ready8) begin
                check("rand8_pending", 32'(q8.size() != 0), 1);
                if (q8.size() != 0) check("rand8_result", 32'({diff8, bout8, ovf8}), 32'(q8.pop_front()));
                recv8++;
            end
            if (out_valid13 && out_ready13) begin
                check("rand13_pending", 32'(q13.size() != 0), 1);
                if (q13.size() != 0) check("rand13_result", 32'({diff13, bout13, ovf13}), 32'(q13.pop_front()));
                recv13++;
            end
            if (in_valid8 && in_ready8) begin
                q8.push_back(ref_pack(8, int'(a8), int'(b8), int'(bin8)));
                sent8++;
            end
            if (in_valid13 && in_ready13) begin
                q13.push_back(ref_pack(13, int'(a13), int'(b13), int'(bin13)));
                sent13++;
            end
            hold8  = in_valid8 && !in_ready8;
            hold13 = in_valid13 && !in_ready13;
        end
        check("rand8_count",  32'(recv8), NRAND);
        check("rand13_count", 32'(recv13), NRAND);
        in_valid8 = 1'b0;
        in_valid13 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
